td4x_core: RTL

TD4X_CORE -- requirements
Module: td4x_core

---
 rtl/td4x_pkg.sv | 24 ++
 rtl/td4x_program_mem.sv | 22 ++
 rtl/td4x_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/td4x_pkg.sv
// rtl/td4x_pkg.sv - TD4X opcode map and FSM state encoding.
package td4x_pkg;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_HLT    = 4'b1000;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/td4x_program_mem.sv
// rtl/td4x_program_mem.sv - program store: sync write, async read, no reset.
module td4x_program_mem #(
   parameter int DW = 4,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [DW+3:0]   wdata_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [DW+3:0]   rdata_o
);

   logic [DW+3:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4x_core.sv
// rtl/td4x_core.sv - TD4-style 4-opcode-bit CPU core with run/step/restart control.
// Optional HLT instruction (opcode 1000) enabled by TD4X_HALT_EN.
module td4x_core
   import td4x_pkg::*;
#(
   parameter int DW = 4,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            step,
   input  logic            restart,
   input  logic [DW-1:0]   in_port,
   input  logic            ld_we,
   input  logic [AW-1:0]   ld_addr,
   input  logic [3:0]      ld_opcode,
   input  logic [DW-1:0]   ld_imm,
   output logic [DW-1:0]   out_port,
   output logic [DW-1:0]   reg_a,
   output logic [DW-1:0]   reg_b,
   output logic [AW-1:0]   pc,
   output logic            carry,
   output logic [1:0]      state,
   output logic            halted
);

   if (AW > DW) begin : g_aw_check
      $error("td4x_core: AW must not exceed DW");
   end

   logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
   logic [AW-1:0] pc_q, pc_d, pc_inc;
   logic          carry_q, carry_d;
   state_e        state_q;
   logic [DW+3:0] instr;
   logic [3:0]    opcode;
   logic [DW-1:0] imm;
   logic [DW:0]   sum_a, sum_b;
   logic          exec, halt_hit;

   td4x_program_mem #(.DW(DW), .AW(AW)) u_mem (
      .clk     (clk),
      .we_i    (ld_we && (state_q != ST_RUN)),
      .waddr_i (ld_addr),
      .wdata_i ({ld_opcode, ld_imm}),
      .raddr_i (pc_q),
      .rdata_o (instr)
   );

   assign opcode = instr[DW+3:DW];
   assign imm    = instr[DW-1:0];
   assign pc_inc = pc_q + 1'b1;
   assign sum_a  = {1'b0, a_q} + {1'b0, imm};
   assign sum_b  = {1'b0, b_q} + {1'b0, imm};
   assign exec   = ((state_q == ST_RUN) && run) || ((state_q == ST_STOP) && step);

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      carry_d  = carry_q;
      pc_d     = pc_q;
      halt_hit = 1'b0;
      if (exec) begin
         carry_d = 1'b0;
         pc_d    = pc_inc;
         case (opcode)
            OP_ADD_A:  {carry_d, a_d} = sum_a;
            OP_MOV_AB: a_d = b_q;
            OP_IN_A:   a_d = in_port;
            OP_MOV_AI: a_d = imm;
            OP_MOV_BA: b_d = a_q;
            OP_ADD_B:  {carry_d, b_d} = sum_b;
            OP_IN_B:   b_d = in_port;
            OP_MOV_BI: b_d = imm;
            OP_OUT_B:  out_d = b_q;
            OP_OUT_I:  out_d = imm;
            OP_JNC:    pc_d = carry_q ? pc_inc : imm[AW-1:0];
            OP_JMP:    pc_d = imm[AW-1:0];
`ifdef TD4X_HALT_EN
            OP_HLT: begin
               pc_d     = pc_q;
               halt_hit = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // restart leaves A, B and out_port alone; only sequencing state is cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         pc_q    <= '0;
         carry_q <= 1'b0;
         state_q <= ST_STOP;
      end else if (restart) begin
         pc_q    <= '0;
         carry_q <= 1'b0;
         state_q <= ST_STOP;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         pc_q    <= pc_d;
         carry_q <= carry_d;
         case (state_q)
            ST_STOP: begin
               if (halt_hit)  state_q <= ST_HALT;
               else if (run)  state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (!run)          state_q <= ST_STOP;
               else if (halt_hit) state_q <= ST_HALT;
            end
            ST_HALT: ;
            default: state_q <= ST_STOP;
         endcase
      end
   end

   assign out_port = out_q;
   assign reg_a    = a_q;
   assign reg_b    = b_q;
   assign pc       = pc_q;
   assign carry    = carry_q;
   assign state    = state_q;
`ifdef TD4X_HALT_EN
   assign halted   = (state_q == ST_HALT);
`else
   assign halted   = 1'b0;
`endif

endmodule
